mem_share_arbiter: RTL and testbench

Shares one synchronous-read, single-port 2^AW x DW RAM between two requesters, A and B. Requesters use req/ack handshakes. Arbitration is round-robin. The block sequences each access through a fixed 4-cycle FSM and returns read data registered alongside ack. It sits between the two client blocks and the RAM's adr/dat_w/we/dat_r pins.

---
 rtl/mem_share_arbiter_if.sv | 16 +
 rtl/mem_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_share_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_share_arbiter_if.sv
// Requester-side handshake bundle for mem_share_arbiter: one instance per client.
// The client drives req/we/adr/wdat; the arbiter returns ack and read data.
interface mem_share_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdat;
  logic          ack;
  logic [DW-1:0] rdat;

  modport master (output req, we, adr, wdat, input ack, rdat);
  modport slave  (input req, we, adr, wdat, output ack, rdat);
endinterface

// File: rtl/mem_share_arbiter.sv
// Round-robin sharing of one synchronous-read single-port RAM between two
// req/ack requesters, each access sequenced IDLE -> ISSUE -> CAPTURE -> ACK.
module mem_share_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_share_arbiter_if.slave a,
  mem_share_arbiter_if.slave b,
  output logic [AW-1:0]     mem_adr,
  output logic [DW-1:0]     mem_dat_w,
  output logic              mem_we,
  input  logic [DW-1:0]     mem_dat_r,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // rr_ptr and grant encode the requester: 0 = A, 1 = B
  logic          rr_ptr;
  logic          rr_ptr_nxt;
  logic          grant;
  logic          grant_nxt;
  logic          gnt_rd;
  logic          gnt_rd_nxt;
  logic          win_b;
  logic          req_any;

  logic          a_ack_reg;
  logic          b_ack_reg;
  logic [DW-1:0] a_rdat_reg;
  logic [DW-1:0] b_rdat_reg;

  logic          a_ack_nxt;
  logic          b_ack_nxt;
  logic [DW-1:0] a_rdat_nxt;
  logic [DW-1:0] b_rdat_nxt;
  logic [AW-1:0] mem_adr_nxt;
  logic [DW-1:0] mem_dat_w_nxt;
  logic          mem_we_nxt;
  logic          busy_nxt;

  assign req_any = a.req | b.req;
  // On a tie the requester that was not granted last wins
  assign win_b   = b.req & (~a.req | ~rr_ptr);

  assign a.ack  = a_ack_reg;
  assign b.ack  = b_ack_reg;
  assign a.rdat = a_rdat_reg;
  assign b.rdat = b_rdat_reg;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = req_any ? ISSUE : IDLE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and grant bookkeeping
  always_comb begin
    rr_ptr_nxt    = rr_ptr;
    grant_nxt     = grant;
    gnt_rd_nxt    = gnt_rd;
    mem_adr_nxt   = mem_adr;
    mem_dat_w_nxt = mem_dat_w;
    mem_we_nxt    = mem_we;
    a_rdat_nxt    = a_rdat_reg;
    b_rdat_nxt    = b_rdat_reg;
    a_ack_nxt     = 1'b0;
    b_ack_nxt     = 1'b0;
    busy_nxt      = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (req_any) begin
          grant_nxt     = win_b;
          rr_ptr_nxt    = win_b;
          mem_we_nxt    = win_b ? b.we   : a.we;
          mem_adr_nxt   = win_b ? b.adr  : a.adr;
          mem_dat_w_nxt = win_b ? b.wdat : a.wdat;
          gnt_rd_nxt    = win_b ? ~b.we  : ~a.we;
        end else begin
          mem_we_nxt    = 1'b0;
        end
      end
      ISSUE: begin
        mem_we_nxt = 1'b0;
      end
      CAPTURE: begin
        // RAM output now reflects the address registered at the end of ISSUE
        if (gnt_rd && !grant) begin
          a_rdat_nxt = mem_dat_r;
        end else if (gnt_rd && grant) begin
          b_rdat_nxt = mem_dat_r;
        end else begin
          a_rdat_nxt = a_rdat_reg;
        end
        a_ack_nxt = ~grant;
        b_ack_nxt = grant;
      end
      ACK: begin
        mem_we_nxt = 1'b0;
      end
      default: begin
        mem_we_nxt = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= 1'b1;
      grant      <= 1'b0;
      gnt_rd     <= 1'b0;
      mem_adr    <= {AW{1'b0}};
      mem_dat_w  <= {DW{1'b0}};
      mem_we     <= 1'b0;
      a_rdat_reg <= {DW{1'b0}};
      b_rdat_reg <= {DW{1'b0}};
      a_ack_reg  <= 1'b0;
      b_ack_reg  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_nxt;
      grant      <= grant_nxt;
      gnt_rd     <= gnt_rd_nxt;
      mem_adr    <= mem_adr_nxt;
      mem_dat_w  <= mem_dat_w_nxt;
      mem_we     <= mem_we_nxt;
      a_rdat_reg <= a_rdat_nxt;
      b_rdat_reg <= b_rdat_nxt;
      a_ack_reg  <= a_ack_nxt;
      b_ack_reg  <= b_ack_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Self-checking bench for mem_share_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin / memory model.
module tb_mem_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] mem_adr;
  logic [7:0] mem_dat_w;
  logic       mem_we;
  logic [7:0] mem_dat_r;
  logic       busy;

  mem_share_arbiter_if #(.AW(4), .DW(8)) ia ();
  mem_share_arbiter_if #(.AW(4), .DW(8)) ib ();

  mem_share_arbiter #(.AW(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (ia.slave),
    .b         (ib.slave),
    .mem_adr   (mem_adr),
    .mem_dat_w (mem_dat_w),
    .mem_we    (mem_we),
    .mem_dat_r (mem_dat_r),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;
  int na    = 0;
  int nb    = 0;

  logic [7:0] ram [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port RAM attached to the arbiter
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_w;
    mem_dat_r <= ram[mem_adr];
  end

  // Ack pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (ia.ack === 1'b1) na++;
    if (ib.ack === 1'b1) nb++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic req, input logic we,
                       input logic [3:0] adr, input logic [7:0] wd);
    if (r == 0) begin
      ia.req = req; ia.we = we; ia.adr = adr; ia.wdat = wd;
    end else begin
      ib.req = req; ib.we = we; ib.adr = adr; ib.wdat = wd;
    end
  endtask

  task automatic do_reset;
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
  endtask

  // One isolated transaction from requester r; returns ack cycle and rdat, ends in IDLE
  task automatic txn(input int r, input logic we, input logic [3:0] adr,
                     input logic [7:0] wd, output logic [7:0] rd, output int ack_cyc);
    logic ackv;
    rd = 8'hxx;
    ack_cyc = -1;
    drive(r, 1'b1, we, adr, wd);
    for (int k = 1; k <= 12 && ack_cyc < 0; k++) begin
      step;
      ackv = (r == 0) ? ia.ack : ib.ack;
      if (ackv === 1'b1) begin
        ack_cyc = k;
        rd = (r == 0) ? ia.rdat : ib.rdat;
      end
    end
    drive(r, 1'b0, we, adr, wd);
    step;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    rst = 1'b1;
    step;
    total++; if (ia.ack !== 1'b0) begin bad++; $display("FAIL reset_a_ack got=%b exp=0", ia.ack); end
    total++; if (ib.ack !== 1'b0) begin bad++; $display("FAIL reset_b_ack got=%b exp=0", ib.ack); end
    total++; if (ia.rdat !== 8'h00) begin bad++; $display("FAIL reset_a_rdat got=%h exp=00", ia.rdat); end
    total++; if (ib.rdat !== 8'h00) begin bad++; $display("FAIL reset_b_rdat got=%h exp=00", ib.rdat); end
    total++; if (mem_adr !== 4'h0) begin bad++; $display("FAIL reset_mem_adr got=%h exp=0", mem_adr); end
    total++; if (mem_dat_w !== 8'h00) begin bad++; $display("FAIL reset_mem_dat_w got=%h exp=00", mem_dat_w); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_write_read;
    logic [7:0] rd;
    int ac;
    int nb0;
    nb0 = nb;
    drive(0, 1'b1, 1'b1, 4'd3, 8'h5A);
    for (int k = 1; k <= 4; k++) begin
      step;
      total++; if (mem_we !== (k == 1)) begin bad++; $display("FAIL wr_mem_we k=%0d got=%b exp=%b", k, mem_we, (k == 1)); end
      total++; if (ia.ack !== (k == 3)) begin bad++; $display("FAIL wr_a_ack k=%0d got=%b exp=%b", k, ia.ack, (k == 3)); end
      total++; if (busy !== (k != 4)) begin bad++; $display("FAIL wr_busy k=%0d got=%b exp=%b", k, busy, (k != 4)); end
      if (k == 1) begin
        total++; if (mem_adr !== 4'd3 || mem_dat_w !== 8'h5A) begin bad++; $display("FAIL wr_bus got=%h/%h exp=3/5a", mem_adr, mem_dat_w); end
      end
      if (k == 3) ia.req = 1'b0;
    end
    txn(0, 1'b0, 4'd3, 8'h00, rd, ac);
    total++; if (rd !== 8'h5A) begin bad++; $display("FAIL rd_a_rdat got=%h exp=5a", rd); end
    total++; if (ac !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", ac); end
    total++; if (nb !== nb0) begin bad++; $display("FAIL rd_b_ack_count got=%0d exp=%0d", nb, nb0); end
  endtask

  task automatic test_simultaneous;
    int a_cyc;
    int b_cyc;
    do_reset;
    a_cyc = -1;
    b_cyc = -1;
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    drive(1, 1'b1, 1'b0, 4'd3, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      step;
      if (ia.ack === 1'b1) begin a_cyc = k; ia.req = 1'b0; end
      if (ib.ack === 1'b1) begin b_cyc = k; ib.req = 1'b0; end
    end
    total++; if (a_cyc !== 3) begin bad++; $display("FAIL simul_a_cycle got=%0d exp=3", a_cyc); end
    total++; if (b_cyc !== 7) begin bad++; $display("FAIL simul_b_cycle got=%0d exp=7", b_cyc); end
    total++; if (ib.rdat !== 8'h5A) begin bad++; $display("FAIL simul_b_rdat got=%h exp=5a", ib.rdat); end
  endtask

  task automatic test_contention;
    do_reset;
    drive(0, 1'b1, 1'b0, 4'd1, 8'h00);
    drive(1, 1'b1, 1'b0, 4'd2, 8'h00);
    for (int k = 1; k <= 32; k++) begin
      step;
      total++; if (ia.ack !== (k % 8 == 3)) begin bad++; $display("FAIL cont_a_ack k=%0d got=%b exp=%b", k, ia.ack, (k % 8 == 3)); end
      total++; if (ib.ack !== (k % 8 == 7)) begin bad++; $display("FAIL cont_b_ack k=%0d got=%b exp=%b", k, ib.ack, (k % 8 == 7)); end
      total++; if (busy !== (k % 4 != 0)) begin bad++; $display("FAIL cont_busy k=%0d got=%b exp=%b", k, busy, (k % 4 != 0)); end
    end
    ia.req = 1'b0;
    ib.req = 1'b0;
    step;
    step;
    step;
    step;
  endtask

  task automatic test_coherence;
    logic [7:0] rd;
    int ac;
    txn(1, 1'b1, 4'd15, 8'hFF, rd, ac);
    txn(0, 1'b0, 4'd15, 8'h00, rd, ac);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL coh_a_rd15 got=%h exp=ff", rd); end
    txn(1, 1'b0, 4'd15, 8'h00, rd, ac);
    total++; if (rd !== 8'hFF) begin bad++; $display("FAIL coh_b_rd15 got=%h exp=ff", rd); end
    txn(1, 1'b1, 4'd0, 8'h00, rd, ac);
    txn(0, 1'b0, 4'd0, 8'h00, rd, ac);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL coh_a_rd0 got=%h exp=00", rd); end
    total++; if (ib.rdat !== 8'hFF) begin bad++; $display("FAIL coh_b_rdat_hold got=%h exp=ff", ib.rdat); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd;
    int ac;
    int na0;
    // Reset in CAPTURE: the write has already reached the RAM
    txn(0, 1'b1, 4'd7, 8'h11, rd, ac);
    drive(0, 1'b1, 1'b1, 4'd7, 8'h22);
    step;
    step;
    na0 = na;
    rst = 1'b1;
    ia.req = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || ia.ack !== 1'b0) begin bad++; $display("FAIL rstcap_outputs got=%b/%b exp=0/0", busy, ia.ack); end
    step;
    rst = 1'b0;
    step; step; step; step;
    total++; if (na !== na0) begin bad++; $display("FAIL rstcap_no_ack got=%0d exp=%0d", na, na0); end
    txn(0, 1'b0, 4'd7, 8'h00, rd, ac);
    total++; if (rd !== 8'h22) begin bad++; $display("FAIL rstcap_read got=%h exp=22", rd); end
    // Reset in ISSUE before the write edge: the write is aborted
    txn(0, 1'b1, 4'd7, 8'h11, rd, ac);
    drive(0, 1'b1, 1'b1, 4'd7, 8'h22);
    step;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rstiss_we_before got=%b exp=1", mem_we); end
    na0 = na;
    rst = 1'b1;
    ia.req = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstiss_we_drop got=%b exp=0", mem_we); end
    step;
    rst = 1'b0;
    step; step; step; step;
    total++; if (na !== na0) begin bad++; $display("FAIL rstiss_no_ack got=%0d exp=%0d", na, na0); end
    txn(0, 1'b0, 4'd7, 8'h00, rd, ac);
    total++; if (rd !== 8'h11) begin bad++; $display("FAIL rstiss_read got=%h exp=11", rd); end
  endtask

  task automatic test_protocol;
    logic [7:0] rd;
    int ac;
    int nb0;
    nb0 = nb;
    drive(0, 1'b1, 1'b0, 4'd3, 8'h00);
    step;
    drive(1, 1'b1, 1'b0, 4'd4, 8'h00);
    step;
    ib.req = 1'b0;
    step;
    total++; if (ia.ack !== 1'b1) begin bad++; $display("FAIL proto_first_ack got=%b exp=1", ia.ack); end
    step;
    // Still requesting in IDLE: new fields describe the second transaction
    drive(0, 1'b1, 1'b1, 4'd2, 8'h77);
    step;
    total++; if (mem_we !== 1'b1 || mem_adr !== 4'd2 || mem_dat_w !== 8'h77) begin bad++; $display("FAIL proto_second_issue got=%b/%h/%h exp=1/2/77", mem_we, mem_adr, mem_dat_w); end
    step;
    step;
    total++; if (ia.ack !== 1'b1) begin bad++; $display("FAIL proto_second_ack got=%b exp=1", ia.ack); end
    ia.req = 1'b0;
    step; step; step;
    total++; if (nb !== nb0) begin bad++; $display("FAIL proto_b_pulse_lost got=%0d exp=%0d", nb, nb0); end
    txn(0, 1'b0, 4'd2, 8'h00, rd, ac);
    total++; if (rd !== 8'h77) begin bad++; $display("FAIL proto_read_back got=%h exp=77", rd); end
  endtask

  task automatic test_random;
    logic [7:0] ref_mem [16];
    logic [7:0] ref_rdat [2];
    logic       pend [2];
    logic       p_we [2];
    logic [3:0] p_adr [2];
    logic [7:0] p_wd [2];
    logic       acks [2];
    logic [7:0] rds [2];
    logic [7:0] rd;
    logic [7:0] exp_rd;
    int         ac;
    int         last;
    int         w;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'(i * 37) ^ 8'h3C;
      txn(0, 1'b1, 4'(i), ref_mem[i], rd, ac);
    end
    ref_rdat[0] = 8'h00;
    ref_rdat[1] = 8'h00;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 0;
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r]  = 1'b1;
          p_we[r]  = 1'($urandom_range(0, 1));
          p_adr[r] = 4'($urandom_range(0, 15));
          p_wd[r]  = 8'($urandom_range(0, 255));
        end
        drive(r, pend[r], p_we[r], p_adr[r], p_wd[r]);
      end
      if (!pend[0] && !pend[1]) begin
        step;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle_busy n=%0d got=%b exp=0", n, busy); end
        continue;
      end
      w = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
      if (p_we[w]) begin
        ref_mem[p_adr[w]] = p_wd[w];
      end else begin
        ref_rdat[w] = ref_mem[p_adr[w]];
      end
      exp_rd = ref_rdat[w];
      step; step; step;
      acks[0] = ia.ack; acks[1] = ib.ack;
      rds[0] = ia.rdat; rds[1] = ib.rdat;
      total++; if (acks[w] !== 1'b1 || acks[1-w] !== 1'b0) begin bad++; $display("FAIL rand_ack n=%0d winner=%0d got=%b%b", n, w, acks[1], acks[0]); end
      total++; if (rds[w] !== exp_rd) begin bad++; $display("FAIL rand_rdat n=%0d req=%0d got=%h exp=%h", n, w, rds[w], exp_rd); end
      total++; if (rds[1-w] !== ref_rdat[1-w]) begin bad++; $display("FAIL rand_other_rdat n=%0d got=%h exp=%h", n, rds[1-w], ref_rdat[1-w]); end
      last = w;
      pend[w] = 1'b0;
      step;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_back_idle n=%0d got=%b exp=0", n, busy); end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    step;
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_write_read;
    test_simultaneous;
    test_contention;
    test_coherence;
    test_reset_mid;
    test_protocol;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
